sample_reader: RTL

SAMPLE_READER -- requirements
Module: sample_reader

---
 rtl/sample_reader_if.sv | 42 ++++
 rtl/sample_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sample_reader_if.sv
// Stream bundle between the sample reader and the DRAM / playback side:
// chunk-address requests out, 128-bit chunks in, 16-bit samples out.
interface sample_reader_if;
    logic         read_addr_tvalid;
    logic         read_addr_tready;
    logic [23:0]  read_addr_tdata;

    logic         chunk_axis_tvalid;
    logic         chunk_axis_tready;
    logic [127:0] chunk_axis_tdata;

    logic         sample_axis_tvalid;
    logic         sample_axis_tready;
    logic [15:0]  sample_axis_tdata;
    logic         sample_axis_tlast;

    modport master (
        output read_addr_tvalid,
        output read_addr_tdata,
        input  read_addr_tready,
        input  chunk_axis_tvalid,
        input  chunk_axis_tdata,
        output chunk_axis_tready,
        output sample_axis_tvalid,
        output sample_axis_tdata,
        output sample_axis_tlast,
        input  sample_axis_tready
    );

    modport slave (
        input  read_addr_tvalid,
        input  read_addr_tdata,
        output read_addr_tready,
        output chunk_axis_tvalid,
        output chunk_axis_tdata,
        input  chunk_axis_tready,
        input  sample_axis_tvalid,
        input  sample_axis_tdata,
        input  sample_axis_tlast,
        output sample_axis_tready
    );
endinterface

// File: rtl/sample_reader.sv
// Instrument sample reader: fetches an instrument's chunk range from DRAM
// and unstacks each 128-bit chunk into eight 16-bit samples.
module sample_reader #(
    parameter int INSTRUMENT_COUNT = 8,
    parameter int MAX_OUTSTANDING  = 4,
    localparam int ID_W  = (INSTRUMENT_COUNT > 1) ?
                           $clog2(INSTRUMENT_COUNT) : 1,
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INSTRUMENT_COUNT:0][23:0] addr_offsets,
    input  logic                          addr_offsets_valid,
    input  logic                          trigger_valid,
    input  logic [ID_W-1:0]               trigger_id,
    sample_reader_if.master               bus,
    output logic                          busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [23:0]      req_addr;
    logic [23:0]      end_addr;
    logic [23:0]      rx_addr;
    logic [23:0]      pend_start;
    logic [23:0]      pend_end;
    logic [OUT_W-1:0] outstanding;
    logic [127:0]     holder;
    logic [2:0]       idx;
    logic             full;
    logic             last_chunk;
    logic             addr_hold;

    logic        id_ok;
    logic        accept;
    logic [23:0] off_start;
    logic [23:0] off_end;
    logic [23:0] nxt_start;
    logic [23:0] nxt_end;
    logic        room;
    logic        rd_hs;
    logic        ck_hs;
    logic        sm_hs;
    logic        last_hs;
    logic        drained;

    always_comb begin
        off_start = '0;
        off_end   = '0;
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
            if (trigger_id == ID_W'(i)) begin
                off_start = addr_offsets[i];
                off_end   = addr_offsets[i+1];
            end
        end
    end

    assign id_ok  = int'(trigger_id) < INSTRUMENT_COUNT;
    assign accept = trigger_valid && addr_offsets_valid && id_ok;

    // A trigger in the exit cycle of DRAIN supersedes the stored one
    assign nxt_start = accept ? off_start : pend_start;
    assign nxt_end   = accept ? off_end   : pend_end;

    assign room = outstanding < OUT_W'(MAX_OUTSTANDING);

    always_comb begin
        bus.read_addr_tvalid = 1'b0;
        case (state)
            RUN:     bus.read_addr_tvalid = (req_addr < end_addr) && room;
            DRAIN:   bus.read_addr_tvalid = addr_hold;
            default: bus.read_addr_tvalid = 1'b0;
        endcase
    end

    assign bus.read_addr_tdata = req_addr;

    assign bus.sample_axis_tvalid = (state == RUN) && full;
    assign bus.sample_axis_tdata  = holder[{idx, 4'b0000} +: 16];
    assign bus.sample_axis_tlast  = bus.sample_axis_tvalid &&
                                    (idx == 3'd7) && last_chunk;

    assign rd_hs   = bus.read_addr_tvalid && bus.read_addr_tready;
    assign sm_hs   = bus.sample_axis_tvalid && bus.sample_axis_tready;
    assign last_hs = sm_hs && bus.sample_axis_tlast;

    always_comb begin
        bus.chunk_axis_tready = 1'b0;
        case (state)
            RUN:     bus.chunk_axis_tready = !full ||
                                             (sm_hs && idx == 3'd7);
            DRAIN:   bus.chunk_axis_tready = 1'b1;
            default: bus.chunk_axis_tready = 1'b0;
        endcase
    end

    assign ck_hs   = bus.chunk_axis_tvalid && bus.chunk_axis_tready;
    assign drained = (outstanding == '0) && !ck_hs &&
                     !bus.read_addr_tvalid;

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_addr    <= '0;
            end_addr    <= '0;
            rx_addr     <= '0;
            pend_start  <= '0;
            pend_end    <= '0;
            outstanding <= '0;
            holder      <= '0;
            idx         <= '0;
            full        <= 1'b0;
            last_chunk  <= 1'b0;
            addr_hold   <= 1'b0;
        end else begin
            if (rd_hs && !ck_hs) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (ck_hs && !rd_hs && outstanding != '0) begin
                outstanding <= outstanding - OUT_W'(1);
            end

            // A presented request stays up until taken, even into DRAIN
            addr_hold <= bus.read_addr_tvalid && !bus.read_addr_tready;

            if (rd_hs) begin
                req_addr <= req_addr + 24'd1;
            end

            case (state)
                IDLE: begin
                    if (accept && off_start < off_end) begin
                        state    <= RUN;
                        req_addr <= off_start;
                        rx_addr  <= off_start;
                        end_addr <= off_end;
                    end
                end
                RUN: begin
                    if (ck_hs) begin
                        holder     <= bus.chunk_axis_tdata;
                        full       <= 1'b1;
                        idx        <= 3'd0;
                        last_chunk <= (rx_addr + 24'd1) == end_addr;
                        rx_addr    <= rx_addr + 24'd1;
                    end else if (sm_hs) begin
                        if (idx == 3'd7) begin
                            full <= 1'b0;
                        end
                        idx <= idx + 3'd1;
                    end
                    if (accept) begin
                        pend_start <= off_start;
                        pend_end   <= off_end;
                        full       <= 1'b0;
                        state      <= DRAIN;
                    end else if (last_hs) begin
                        full  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        if (nxt_start < nxt_end) begin
                            state    <= RUN;
                            req_addr <= nxt_start;
                            rx_addr  <= nxt_start;
                            end_addr <= nxt_end;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        pend_start <= off_start;
                        pend_end   <= off_end;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
